// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_RELEASE,
        ST_DONE,
        ST_ERROR
    } ld_state_e;

    // Checksum seed applied whenever a new load starts.
    localparam logic [7:0] CSUM_INIT = 8'h00;

    // True when an image of n words fits a memory of 2**addr_w words.
    function automatic logic len_fits(input logic [15:0] n, input int unsigned addr_w);
        return {16'b0, n} <= (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Loader side: consumes the stream, drives memory writes.
    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    // Environment side: byte source and instruction memory.
    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word packer: first byte lands in [7:0], fourth in [31:24].
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        on_last,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sr_q, sr_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    // High when the next accepted byte completes a word.
    assign on_last    = (cnt_q == 2'd3);
    assign word_valid = word_valid_q;
    assign word       = word_q;

    // Shift bytes in from the top; publish the packed word on the 4th byte.
    always_comb begin
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (byte_valid) begin
            sr_d  = {byte_data, sr_q[23:8]};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                word_d       = {byte_data, sr_q};
                word_valid_d = 1'b1;
            end
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            sr_q         <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives len/payload/checksum, writes instruction memory,
// and holds the core in reset until the image is verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    imem_loader_if.master   bus,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int unsigned REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [REL_W-1:0] REL_INIT = REL_W'(RELEASE_CYCLES - 1);

    ld_state_e         state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic        rx_ready;
    logic        accept;
    logic        pk_clr;
    logic        pk_valid;
    logic        pk_on_last;
    logic        pk_word_valid;
    logic [31:0] pk_word;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pk_clr),
        .byte_valid (pk_valid),
        .byte_data  (bus.rx_data),
        .on_last    (pk_on_last),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    // Status and handshake outputs decoded from the registered state.
    assign rx_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign accept   = bus.rx_valid & rx_ready;
    assign busy     = rx_ready || (state_q == ST_RELEASE);
    assign core_rst = (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign err      = (state_q == ST_ERROR);

    assign bus.rx_ready   = rx_ready;
    assign bus.imem_we    = pk_word_valid;
    assign bus.imem_wdata = pk_word;
    assign bus.imem_addr  = addr_q;

    // Next-state, counters and checksum.
    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        rel_cnt_d = rel_cnt_q;
        addr_d    = addr_q;
        pk_clr    = 1'b0;
        pk_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_LO;
                    csum_d  = CSUM_INIT;
                    idx_d   = '0;
                    pk_clr  = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_lo_d = bus.rx_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d = {bus.rx_data, len_lo_q};
                    if (!len_fits({bus.rx_data, len_lo_q}, ADDR_W)) begin
                        state_d = ST_ERROR;
                    end else if ({bus.rx_data, len_lo_q} == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    pk_valid = 1'b1;
                    csum_d   = csum_q ^ bus.rx_data;
                    if (pk_on_last) begin
                        addr_d = idx_q[ADDR_W-1:0];
                        idx_d  = idx_q + (ADDR_W+1)'(1);
                        if ((32'(idx_q) + 32'd1) == 32'(len_q)) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (bus.rx_data == csum_q) begin
                        state_d   = ST_RELEASE;
                        rel_cnt_d = REL_INIT;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_RELEASE: begin
                if (rel_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    rel_cnt_d = rel_cnt_q - REL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Loader state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_lo_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            csum_q    <= CSUM_INIT;
            rel_cnt_q <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            rel_cnt_q <= rel_cnt_d;
            addr_q    <= addr_d;
        end
    end

endmodule
